// File: rtl/conv_pe_multi.sv
// conv_pe_multi: NUM_FILTERS-wide 1-D convolution PE with a sliding window,
// 3-stage MAC pipeline and credited psum FIFO. Optional feature: `PE_RELU_EN.
module conv_pe_multi #(
    parameter int NUM_FILTERS          = 4,
    parameter int DATA_WIDTH           = 8,
    parameter int FILTER_WIDTH         = 8,
    parameter int PSUM_WIDTH           = 20,
    parameter int FILTER_DEPTH         = 16,
    parameter int WIN_DEPTH            = 32,
    parameter int PSUM_DEPTH           = 8,
    parameter int STRIDE_SIZE          = 3,
    parameter int FILTER_SIZE_REG_SIZE = 5
) (
    input  logic                                clk,
    input  logic                                rst,
    input  logic                                start,
    input  logic                                job_release,
    input  logic [STRIDE_SIZE-1:0]              stride,
    input  logic [FILTER_SIZE_REG_SIZE-1:0]     filter_size,
    input  logic                                filt_valid,
    output logic                                filt_ready,
    input  logic [NUM_FILTERS*FILTER_WIDTH-1:0] filt_data,
    input  logic                                ifmap_valid,
    output logic                                ifmap_ready,
    input  logic [DATA_WIDTH-1:0]               ifmap_data,
    input  logic                                ifmap_last,
    output logic                                psum_valid,
    input  logic                                psum_ready,
    output logic [NUM_FILTERS*PSUM_WIDTH-1:0]   psum_data,
    output logic                                row_done,
    output logic                                done,
    output logic                                busy
);

    localparam int KMAX = (FILTER_DEPTH < WIN_DEPTH) ? FILTER_DEPTH : WIN_DEPTH;
    localparam int AW   = $clog2(WIN_DEPTH);
    localparam int OW   = AW + 1;
    localparam int TW   = (FILTER_DEPTH > 1) ? $clog2(FILTER_DEPTH) : 1;
    localparam int FAW  = (PSUM_DEPTH > 1) ? $clog2(PSUM_DEPTH) : 1;
    localparam int CW   = $clog2(PSUM_DEPTH + 1);
    localparam int FW   = NUM_FILTERS * FILTER_WIDTH;
    localparam int PW   = NUM_FILTERS * PSUM_WIDTH;
    localparam int MW   = DATA_WIDTH + FILTER_WIDTH;

    typedef enum logic [1:0] {IDLE, LOADF, RUN, DRAIN} state_t;

    state_t state, state_n;
    logic   done_n;

    logic [OW-1:0] k_reg, s_reg;
    logic [TW-1:0] klast, load_cnt;
    logic [31:0]   k_cfg, s_cfg;

    logic [DATA_WIDTH-1:0] win_mem [WIN_DEPTH];
    logic [FW-1:0]         filt_mem [FILTER_DEPTH];
    logic [PW-1:0]         fifo_mem [PSUM_DEPTH];

    logic [AW-1:0]  base, wr_ptr;
    logic [OW-1:0]  occ;
    logic           last_held;
    logic           seq_active;
    logic [TW-1:0]  tap_cnt, cur_tap;
    logic [CW-1:0]  pend, fifo_cnt;
    logic [FAW-1:0] fifo_rd, fifo_wr;

    logic          s0_valid, s0_first, s0_last;
    logic [AW-1:0] s0_addr;
    logic [TW-1:0] s0_tap;
    logic                  s1_valid, s1_first, s1_last;
    logic [DATA_WIDTH-1:0] s1_x;
    logic [FW-1:0]         s1_w;
    logic                  s2_valid, s2_first, s2_last;
    logic [PSUM_WIDTH-1:0] s2_p  [NUM_FILTERS];
    logic [PSUM_WIDTH-1:0] acc   [NUM_FILTERS];
    logic [PSUM_WIDTH-1:0] acc_n [NUM_FILTERS];
    logic signed [MW-1:0]  prod_c [NUM_FILTERS];
    logic [PW-1:0]         wr_data;

    logic mac_on, credit_ok, can_start, issuing, tap_last, discard;
    logic ifmap_fire, filt_fire, push, pop;

    // Clamp K into [1, KMAX] first, then S into [1, K].
    always_comb begin
        k_cfg = 32'(filter_size);
        if (k_cfg == 32'd0)
            k_cfg = 32'd1;
        else if (k_cfg > 32'(KMAX))
            k_cfg = 32'(KMAX);
        s_cfg = 32'(stride);
        if (s_cfg == 32'd0)
            s_cfg = 32'd1;
        else if (s_cfg > k_cfg)
            s_cfg = k_cfg;
    end

    assign busy        = (state != IDLE);
    assign filt_ready  = (state == LOADF);
    assign ifmap_ready = (state == RUN) && (occ < OW'(WIN_DEPTH)) && !last_held;
    assign filt_fire   = filt_valid && filt_ready;
    assign ifmap_fire  = ifmap_valid && ifmap_ready;
    assign psum_valid  = (fifo_cnt != '0);
    assign psum_data   = psum_valid ? fifo_mem[fifo_rd] : '0;
    assign push        = s2_valid && s2_last;
    assign pop         = psum_valid && psum_ready;

    // A window only starts when its result has a guaranteed FIFO slot.
    assign mac_on    = (state == RUN) || (state == DRAIN);
    assign credit_ok = ({1'b0, fifo_cnt} + {1'b0, pend}) < (CW + 1)'(PSUM_DEPTH);
    assign can_start = mac_on && !seq_active && (occ >= k_reg) && credit_ok;
    assign issuing   = seq_active || can_start;
    assign cur_tap   = seq_active ? tap_cnt : '0;
    assign tap_last  = issuing && (cur_tap == klast);
    assign discard   = (last_held || state == DRAIN) && !seq_active && (occ < k_reg);

    always_comb begin
        state_n = state;
        done_n  = 1'b0;
        unique case (state)
            IDLE:  if (start) state_n = LOADF;
            LOADF: if (filt_fire && load_cnt == klast) state_n = RUN;
            RUN:   if (job_release) state_n = DRAIN;
            DRAIN: begin
                if (occ == '0 && !seq_active && pend == '0) begin
                    state_n = IDLE;
                    done_n  = 1'b1;
                end
            end
            default: state_n = IDLE;
        endcase
    end

    always_comb begin
        wr_data = '0;
        for (int f = 0; f < NUM_FILTERS; f++) begin
            prod_c[f] = $signed(s1_x) * $signed(s1_w[f*FILTER_WIDTH +: FILTER_WIDTH]);
            acc_n[f]  = s2_first ? s2_p[f] : acc[f] + s2_p[f];
`ifdef PE_RELU_EN
            wr_data[f*PSUM_WIDTH +: PSUM_WIDTH] = acc_n[f][PSUM_WIDTH-1] ? '0 : acc_n[f];
`else
            wr_data[f*PSUM_WIDTH +: PSUM_WIDTH] = acc_n[f];
`endif
        end
    end

    always_ff @(posedge clk) begin
        if (ifmap_fire) win_mem[wr_ptr] <= ifmap_data;
        if (filt_fire) filt_mem[load_cnt] <= filt_data;
        if (push) fifo_mem[fifo_wr] <= wr_data;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= IDLE;
            done       <= 1'b0;
            row_done   <= 1'b0;
            k_reg      <= OW'(1);
            s_reg      <= OW'(1);
            klast      <= '0;
            load_cnt   <= '0;
            base       <= '0;
            wr_ptr     <= '0;
            occ        <= '0;
            last_held  <= 1'b0;
            seq_active <= 1'b0;
            tap_cnt    <= '0;
            pend       <= '0;
            fifo_cnt   <= '0;
            fifo_rd    <= '0;
            fifo_wr    <= '0;
        end else begin
            state    <= state_n;
            done     <= done_n;
            row_done <= discard && last_held;
            if (state == IDLE && start) begin
                k_reg    <= OW'(k_cfg);
                s_reg    <= OW'(s_cfg);
                klast    <= TW'(k_cfg - 32'd1);
                load_cnt <= '0;
            end else if (filt_fire) begin
                load_cnt <= load_cnt + 1'b1;
            end
            if (ifmap_fire) wr_ptr <= wr_ptr + 1'b1;
            if (discard) begin
                occ       <= '0;
                base      <= wr_ptr;
                last_held <= 1'b0;
            end else begin
                occ <= occ + OW'(ifmap_fire) - (tap_last ? s_reg : '0);
                if (tap_last) base <= base + AW'(s_reg);
                if (ifmap_fire && ifmap_last) last_held <= 1'b1;
            end
            if (issuing) begin
                seq_active <= !tap_last;
                tap_cnt    <= tap_last ? '0 : cur_tap + 1'b1;
            end
            pend     <= pend + CW'(can_start) - CW'(push);
            fifo_cnt <= fifo_cnt + CW'(push) - CW'(pop);
            if (push) fifo_wr <= (fifo_wr == FAW'(PSUM_DEPTH - 1)) ? '0 : fifo_wr + 1'b1;
            if (pop) fifo_rd <= (fifo_rd == FAW'(PSUM_DEPTH - 1)) ? '0 : fifo_rd + 1'b1;
        end
    end

    // Address, operand, product and accumulate stages.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s0_valid <= 1'b0;
            s0_first <= 1'b0;
            s0_last  <= 1'b0;
            s0_addr  <= '0;
            s0_tap   <= '0;
            s1_valid <= 1'b0;
            s1_first <= 1'b0;
            s1_last  <= 1'b0;
            s1_x     <= '0;
            s1_w     <= '0;
            s2_valid <= 1'b0;
            s2_first <= 1'b0;
            s2_last  <= 1'b0;
            for (int f = 0; f < NUM_FILTERS; f++) begin
                s2_p[f] <= '0;
                acc[f]  <= '0;
            end
        end else begin
            s0_valid <= issuing;
            s0_first <= can_start;
            s0_last  <= tap_last;
            s0_addr  <= base + AW'(cur_tap);
            s0_tap   <= cur_tap;
            s1_valid <= s0_valid;
            s1_first <= s0_first;
            s1_last  <= s0_last;
            s1_x     <= win_mem[s0_addr];
            s1_w     <= filt_mem[s0_tap];
            s2_valid <= s1_valid;
            s2_first <= s1_first;
            s2_last  <= s1_last;
            for (int f = 0; f < NUM_FILTERS; f++) begin
                s2_p[f] <= {{(PSUM_WIDTH - MW){prod_c[f][MW-1]}}, prod_c[f]};
                if (s2_valid) acc[f] <= acc_n[f];
            end
        end
    end

endmodule

// File: tb/tb_conv_pe_multi.sv
// Bench for conv_pe_multi: a software convolution model fills a scoreboard
// that is drained in order on every psum handshake.
`timescale 1ns/1ps
module tb_conv_pe_multi;

    localparam int NF  = 4;
    localparam int DW  = 8;
    localparam int FWD = 8;
    localparam int PWD = 20;
    localparam int FD  = 16;
    localparam int PD  = 2;
    localparam int PW  = NF * PWD;
`ifdef PE_RELU_EN
    localparam bit RELU = 1'b1;
`else
    localparam bit RELU = 1'b0;
`endif

    logic clk = 1'b0;
    logic rst;
    logic start, job_release;
    logic [2:0] stride;
    logic [4:0] filter_size;
    logic filt_valid, filt_ready;
    logic [NF*FWD-1:0] filt_data;
    logic ifmap_valid, ifmap_ready, ifmap_last;
    logic [DW-1:0] ifmap_data;
    logic psum_valid, psum_ready;
    logic [PW-1:0] psum_data;
    logic row_done, done, busy;

    always #5 clk = ~clk;

    conv_pe_multi #(.PSUM_DEPTH(PD)) dut (
        .clk(clk), .rst(rst), .start(start), .job_release(job_release),
        .stride(stride), .filter_size(filter_size),
        .filt_valid(filt_valid), .filt_ready(filt_ready), .filt_data(filt_data),
        .ifmap_valid(ifmap_valid), .ifmap_ready(ifmap_ready),
        .ifmap_data(ifmap_data), .ifmap_last(ifmap_last),
        .psum_valid(psum_valid), .psum_ready(psum_ready), .psum_data(psum_data),
        .row_done(row_done), .done(done), .busy(busy)
    );

    int tests = 0;
    int fails = 0;
    logic [PW-1:0] sb [$];
    int filt [NF][FD];
    int cyc = 0, acc_cnt = 0, out_cnt = 0, rd_cnt = 0, done_cnt = 0;
    int first_acc = -1, first_pv = -1, job_rd0 = 0;
    bit feed_done;
    int jk, js;
    int row [$];

    task automatic check(input string tag, input logic [PW-1:0] obs,
                         input logic [PW-1:0] exp);
        tests++;
        if (obs !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    always @(posedge clk) cyc++;

    always @(negedge clk) begin
        if (!rst) begin
            if (ifmap_valid && ifmap_ready) begin
                if (first_acc < 0) first_acc = cyc;
                acc_cnt++;
            end
            if (psum_valid && first_pv < 0) first_pv = cyc;
            if (row_done) rd_cnt++;
            if (done) done_cnt++;
            if (psum_valid && psum_ready) begin
                check("sb_nonempty", PW'(sb.size() != 0), PW'(1));
                if (sb.size() != 0) check("psum", psum_data, sb.pop_front());
                out_cnt++;
            end
        end
    end

    function automatic void expect_row(input int r[$], input int k, input int s);
        logic [PW-1:0] v;
        logic [PWD-1:0] w;
        int sum;
        for (int b = 0; b + k <= r.size(); b += s) begin
            v = '0;
            for (int f = 0; f < NF; f++) begin
                sum = 0;
                for (int t = 0; t < k; t++) sum += r[b+t] * filt[f][t];
                w = PWD'(sum);
                if (RELU && w[PWD-1]) w = '0;
                v[f*PWD +: PWD] = w;
            end
            sb.push_back(v);
        end
    endfunction

    task automatic clear_filt();
        for (int f = 0; f < NF; f++)
            for (int t = 0; t < FD; t++) filt[f][t] = 0;
    endtask

    task automatic start_job(input int fs, input int st, output int k, output int s);
        int t;
        k = (fs == 0) ? 1 : (fs > FD ? FD : fs);
        s = (st == 0) ? 1 : (st > k ? k : st);
        job_rd0 = rd_cnt;
        filter_size = 5'(fs);
        stride = 3'(st);
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        for (int i = 0; i < k; i++) begin
            filt_valid = 1'b1;
            for (int f = 0; f < NF; f++) filt_data[f*FWD +: FWD] = FWD'(filt[f][i]);
            t = 0;
            while (!filt_ready && t < 100) begin
                @(posedge clk); #1;
                t++;
            end
            if (t >= 100) begin
                check("filt_timeout", PW'(filt_ready), PW'(1));
                break;
            end
            @(posedge clk); #1;
        end
        filt_valid = 1'b0;
    endtask

    task automatic send_row(input int r[$], input bit with_last);
        int t;
        for (int i = 0; i < r.size(); i++) begin
            ifmap_valid = 1'b1;
            ifmap_data  = DW'(r[i]);
            ifmap_last  = with_last && (i == r.size() - 1);
            t = 0;
            while (!ifmap_ready && t < 1000) begin
                @(posedge clk); #1;
                t++;
            end
            if (t >= 1000) begin
                check("ifmap_timeout", PW'(ifmap_ready), PW'(1));
                break;
            end
            @(posedge clk); #1;
        end
        ifmap_valid = 1'b0;
        ifmap_last  = 1'b0;
    endtask

    task automatic finish_job(input int exp_rows);
        int d0, t;
        d0 = done_cnt;
        job_release = 1'b1;
        @(posedge clk); #1;
        job_release = 1'b0;
        t = 0;
        while (done_cnt == d0 && t < 1000) begin
            @(posedge clk); #1;
            t++;
        end
        check("done_pulse", PW'(done_cnt - d0), PW'(1));
        repeat (4) @(posedge clk);
        #1;
        check("busy_idle", PW'(busy), PW'(0));
        check("sb_empty", PW'(sb.size()), PW'(0));
        check("row_done_cnt", PW'(rd_cnt - job_rd0), PW'(exp_rows));
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_filt_ready"}, PW'(filt_ready), PW'(0));
        check({tag, "_ifmap_ready"}, PW'(ifmap_ready), PW'(0));
        check({tag, "_psum_valid"}, PW'(psum_valid), PW'(0));
        check({tag, "_psum_data"}, psum_data, PW'(0));
        check({tag, "_row_done"}, PW'(row_done), PW'(0));
        check({tag, "_done"}, PW'(done), PW'(0));
        check({tag, "_busy"}, PW'(busy), PW'(0));
    endtask

    task automatic filt_a();
        clear_filt();
        filt[0][0] = 1; filt[0][1] = 1; filt[0][2] = 1;
        filt[1][0] = 1; filt[1][1] = 0; filt[1][2] = -1;
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish");
        $display("[TB] %0d tests run, %0d failed", tests, fails + 1);
        $fatal(1);
    end

    initial begin
        rst = 1'b1; start = 1'b0; job_release = 1'b0;
        stride = '0; filter_size = '0;
        filt_valid = 1'b0; filt_data = '0;
        ifmap_valid = 1'b0; ifmap_data = '0; ifmap_last = 1'b0;
        psum_ready = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        check_reset_outputs("reset");
        rst = 1'b0;
        @(posedge clk); #1;

        // K=3 S=1, short row, then a too-short row, then a minimal row
        filt_a();
        first_acc = -1;
        first_pv = -1;
        start_job(3, 1, jk, js);
        row = '{1, 2, 3, 4, 5};
        expect_row(row, jk, js);
        send_row(row, 1'b1);
        row = '{7, 8};
        expect_row(row, jk, js);
        send_row(row, 1'b1);
        row = '{1, 2, 3};
        expect_row(row, jk, js);
        send_row(row, 1'b1);
        finish_job(3);
        check("latency", PW'(first_pv - first_acc), PW'(9));

        // K=3 S=2 with wider filter values
        clear_filt();
        filt[0][0] = 1; filt[0][1] = 1; filt[0][2] = 1;
        filt[1][0] = 2; filt[1][1] = -1; filt[1][2] = 3;
        filt[2][0] = -128; filt[2][1] = 127; filt[2][2] = -5;
        filt[3][0] = 100; filt[3][1] = 100; filt[3][2] = 100;
        start_job(3, 2, jk, js);
        row = '{1, 2, 3, 4, 5, 6};
        expect_row(row, jk, js);
        send_row(row, 1'b1);
        row = '{-128, -128, -128, 127};
        expect_row(row, jk, js);
        send_row(row, 1'b1);
        finish_job(2);

        // K=0 -> 1, stride above K -> K
        clear_filt();
        filt[0][0] = 2; filt[1][0] = -3; filt[2][0] = 127; filt[3][0] = -128;
        start_job(0, 5, jk, js);
        row = '{5, -7, 0, 127};
        expect_row(row, jk, js);
        send_row(row, 1'b1);
        finish_job(1);

        // K=31 clamps to 16, S=7
        for (int f = 0; f < NF; f++)
            for (int t = 0; t < FD; t++) filt[f][t] = int'($urandom_range(255)) - 128;
        start_job(31, 7, jk, js);
        row.delete();
        for (int i = 0; i < 30; i++) row.push_back(int'($urandom_range(255)) - 128);
        expect_row(row, jk, js);
        send_row(row, 1'b1);
        finish_job(1);

        // Backpressure: FIFO fills, window fills, then resumes
        clear_filt();
        filt[0][0] = 3; filt[1][0] = -1; filt[2][0] = 1;
        start_job(1, 1, jk, js);
        psum_ready = 1'b0;
        row.delete();
        for (int i = 0; i < 40; i++) row.push_back(int'($urandom_range(255)) - 128);
        expect_row(row, jk, js);
        acc_cnt = 0;
        out_cnt = 0;
        feed_done = 1'b0;
        fork
            begin
                send_row(row, 1'b1);
                feed_done = 1'b1;
            end
        join_none
        repeat (150) @(posedge clk);
        #1;
        check("bp_accepted", PW'(acc_cnt), PW'(32 + PD));
        check("bp_ifmap_ready", PW'(ifmap_ready), PW'(0));
        check("bp_psum_valid", PW'(psum_valid), PW'(1));
        check("bp_no_pops", PW'(out_cnt), PW'(0));
        psum_ready = 1'b1;
        for (int t = 0; t < 2000 && !feed_done; t++) @(posedge clk);
        #1;
        check("bp_feed_done", PW'(feed_done), PW'(1));
        finish_job(1);
        check("bp_out_cnt", PW'(out_cnt), PW'(40));

        // Reset with results buffered and a sequence in flight
        filt_a();
        start_job(3, 1, jk, js);
        psum_ready = 1'b0;
        row = '{1, 2, 3, 4, 5, 6};
        send_row(row, 1'b0);
        repeat (8) @(posedge clk);
        #1;
        check("pre_rst_psum_valid", PW'(psum_valid), PW'(1));
        rst = 1'b1;
        #1;
        check_reset_outputs("midrst");
        sb.delete();
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        psum_ready = 1'b1;
        @(posedge clk); #1;
        start_job(3, 1, jk, js);
        row = '{1, 2, 3, 4, 5};
        expect_row(row, jk, js);
        send_row(row, 1'b1);
        finish_job(1);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/conv_pe_multi.md
# conv_pe_multi

Next-generation 1-D convolution processing element. One IFMap row stream is convolved against NUM_FILTERS filters in parallel, with configurable filter size and stride. A row is buffered in a sliding-window scratch pad, fed through a 3-stage read/multiply/accumulate pipeline, and the per-filter partial sums go into an output FIFO with valid/ready backpressure. The block sits between the global IFMap/filter buffers and the psum collection network, and supersedes the single-filter flag-tagged datapath.

## Interface
- NUM_FILTERS, 4, filters computed in parallel per IFMap element
- DATA_WIDTH, 8, signed IFMap element width
- FILTER_WIDTH, 8, signed filter tap width
- PSUM_WIDTH, 20, signed accumulator/output width per filter
- FILTER_DEPTH, 16, max taps per filter (filter spad rows)
- WIN_DEPTH, 32, sliding-window capacity (power of two)
- PSUM_DEPTH, 8, output FIFO entries
- STRIDE_SIZE, 3, stride field width
- FILTER_SIZE_REG_SIZE, 5, filter-size field width

Ports:
- clk  in  1  clock; all state updates on the rising edge
- rst  in  1  reset, asynchronous and active-high
- start  in  1  pulse in IDLE; latches stride and filter_size
- release  in  1  pulse in RUN; ends the job after drain
- stride  in  STRIDE_SIZE  window advance per output
- filter_size  in  FILTER_SIZE_REG_SIZE  taps K
- filt_valid / filt_ready  in/out  1  filter tap handshake
- filt_data  in  NUM_FILTERS*FILTER_WIDTH  tap t for all filters; filter f at [f*FILTER_WIDTH +: FILTER_WIDTH]
- ifmap_valid / ifmap_ready  in/out  1  IFMap handshake
- ifmap_data  in  DATA_WIDTH  element
- ifmap_last  in  1  marks last element of a row
- psum_valid / psum_ready  out/in  1  psum handshake
- psum_data  out  NUM_FILTERS*PSUM_WIDTH  filter f at [f*PSUM_WIDTH +: PSUM_WIDTH]
- row_done  out  1  one-cycle pulse when a row is fully consumed
- done  out  1  one-cycle pulse on the DRAIN to IDLE transition
- busy  out  1  high when not in IDLE

## Operation
- FSM states: IDLE, LOADF, RUN, DRAIN.
  - IDLE -> LOADF on start.
  - LOADF accepts K beats with filt_ready=1, then goes to RUN.
  - RUN -> DRAIN on release.
  - DRAIN -> IDLE once the window is empty and no MAC is in flight.
- Config clamping at start: K=0 is treated as 1; K>FILTER_DEPTH or K>WIN_DEPTH is clamped to min(FILTER_DEPTH, WIN_DEPTH). S=0 is treated as 1; S>K is clamped to K.
- Window is a circular buffer with read base, write pointer and occupancy count; pointers wrap modulo WIN_DEPTH.
- ifmap_ready=1 in RUN when occupancy<WIN_DEPTH and no ifmap_last is held in the window.
- MAC issue happens when occupancy>=K, no sequence is active, and (FIFO count + in-flight results) < PSUM_DEPTH.
  - Issue runs K consecutive cycles, tap t = 0..K-1 reading window[base+t] and filter[t].
  - On issue completion, base advances by S and occupancy decrements by S.
- Row end: once the ifmap_last element is in the window and occupancy<K, the remaining elements are discarded, occupancy goes to 0, and row_done pulses.
  - A row of length L produces floor((L-K)/S)+1 outputs, or 0 if L<K.
- Simultaneous ifmap accept and base advance in one cycle: occupancy = occ+1-S.
- Arithmetic: signed DATA_WIDTH x FILTER_WIDTH products, sign-extended into PSUM_WIDTH. Accumulation wraps modulo 2^PSUM_WIDTH. Tap 0 loads the accumulator; later taps add to it.
- Filters persist across rows and are reloaded only through IDLE->LOADF.
- start in non-IDLE states and release in non-RUN states are ignored.

## Timing
- Reset: filt_ready=0, ifmap_ready=0, psum_valid=0, psum_data=0, row_done=0, done=0, busy=0. FSM goes to IDLE; pointers, counts and FIFO are cleared.
- Reset mid-operation aborts immediately; in-flight results and FIFO contents are lost.
- Pipeline: tap issued in cycle c, operands registered at c+1, product at c+2, accumulate at c+3.
- For a first tap in cycle c, the result is written to the FIFO at the end of c+K+2. With an empty FIFO, psum_valid is high in cycle c+K+3.
- Output FIFO is show-ahead; a transfer occurs when psum_valid && psum_ready. Credit-based issue guarantees the FIFO never overflows and the pipeline never stalls mid-sequence.
- Back-to-back windows issue with no bubble: the next issue cycle follows the last tap.

## Configuration
- PE_RELU_EN defined: each filter's final sum is clamped to 0 if negative before the FIFO write. Adds no latency.
- PE_RELU_EN undefined: the raw wrapped signed sum is written.

## Test plan
- K=3, S=1, f0=[1,1,1], f1=[1,0,-1], f2=f3=0, row [1,2,3,4,5] -> f0 outputs 6,9,12; f1 outputs -2,-2,-2; row_done pulses once.
- Same stimulus with PE_RELU_EN -> f1 outputs 0,0,0; f0 unchanged.
- K=3, S=2, row [1..6], f0=[1,1,1] -> exactly 2 outputs, 6 and 12; element 6 is discarded at row end.
- K=3, row [7,8] with ifmap_last on 8 -> no psum, row_done pulse; the next row [1,2,3] yields f0=6.
- PSUM_DEPTH=2, psum_ready=0, K=1, S=1, 40-element row -> exactly 2 results buffered, ifmap_ready drops when occupancy reaches 32; raising psum_ready resumes with no lost or duplicated outputs.
- rst asserted mid-sequence -> all outputs return to their reset values the same cycle; after start, a fresh K=3 run reproduces the first test's values.
